spi_slave: RTL and testbench
============================

# spi_slave

SPI responder for the far end of the team's SPI master link. It oversamples `sclk`, `ss_n` and `mosi` into the `clk` domain and deserializes `mosi` into `rx_data`. It serializes a one-word-buffered `tx_data` onto `miso`. It supports all four SPI modes and multi-word frames within one `ss_n` assertion, and sits between the SPI pads and a register-file or FIFO client.

## Interface
- `SPI_MODE`, default 0: {CPOL, CPHA}. CPOL is the idle level of `sclk`; CPHA=1 samples on the trailing edge.
- `DATA_WIDTH`, default 8: word length in bits, ≥2, MSB first.
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`/`ss_n`/`mosi`, ≥2.
- `clk` input 1: system clock. Must be ≥ 8× the `sclk` frequency.
- `rst_n` input 1: reset, synchronous, active-low.
- `sclk` input 1: SPI clock from the master. Asynchronous to `clk`.
- `ss_n` input 1: chip select, active-low. Asynchronous to `clk`.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master. Forced to 0 while not selected.
- `miso_oe` output 1: pad output enable; high while a frame is active.
- `tx_data` input DATA_WIDTH: next word to transmit.
- `tx_valid` input 1: `tx_data` is offered.
- `tx_ready` output 1: TX buffer is empty; a word is accepted on `tx_valid & tx_ready`.
- `rx_data` output DATA_WIDTH: last complete received word. Held until the next complete word.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: frame active (state ACTIVE).
- `tx_underrun` output 1: one-cycle pulse when a word starts with an empty TX buffer.
- `frame_err` output 1: one-cycle pulse when `ss_n` rises mid-word.

## Operation
- **Synchronization:** `sclk`, `ss_n` and `mosi` each pass through SYNC_STAGES flops. Edge detection on the synced `sclk` uses one more flop.
  - Leading edge: the transition away from CPOL.
  - Trailing edge: the transition back to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. The other edge is the shift edge.
- **State machine:** IDLE, ACTIVE.
  - IDLE→ACTIVE on a synced `ss_n` falling edge. On entry:
    - bit counter cleared;
    - shifter loaded from the TX buffer if it is full, else with all zeros plus a `tx_underrun` pulse;
    - `miso_oe` set to 1.
  - ACTIVE→IDLE on a synced `ss_n` high.
  - `sclk` edges are ignored in IDLE.
- **Sample edge:** shift synced `mosi` into `rx_shift` LSB and increment the bit counter. When the count reaches DATA_WIDTH:
  - `rx_data` ← the completed word (including the bit sampled this edge);
  - `rx_valid` pulses;
  - the counter wraps to 0.
- **Shift edge:** shift `tx_shift` left, filling with 0.
  - CPHA=1: the first leading edge of each word loads the shifter instead of shifting. This applies from the second word on; for the first word the load on IDLE→ACTIVE applies and that edge is a no-op.
  - CPHA=0: after the last sample of a word, the following trailing edge loads the next word (or zeros plus `tx_underrun`) instead of shifting.
- `miso` = `tx_shift[DATA_WIDTH-1]` while ACTIVE, else 0.
- **TX buffer:** a one-entry register.
  - `tx_ready` = buffer empty.
  - A shifter load empties the buffer; `tx_ready` rises the next cycle.
  - A `tx_valid` in the same cycle as a load of an empty buffer writes the buffer for the following word. The current word still underruns.
- **Abort:** `ss_n` high with bit counter ≠ 0 causes:
  - a `frame_err` pulse;
  - the partial `rx_shift` is discarded, and `rx_data` is unchanged;
  - the buffer contents are retained.
  
  `ss_n` high with counter = 0 is a clean end, with no pulse.

## Timing
- **Reset values:**
  - outputs: `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `tx_underrun`=0, `frame_err`=0;
  - internal: state IDLE, buffer empty, shifters and counter 0.
  - Reset mid-frame takes effect on the next `clk` edge. The remainder of the frame is ignored until a new `ss_n` falling edge.
- **Input-to-response latency:** an `sclk` or `ss_n` pin edge produces a `clk`-domain action SYNC_STAGES+1 cycles later.
  - `miso` changes at most SYNC_STAGES+2 cycles after a shift edge on the pin.
  - The 8× ratio guarantees `miso` is stable before the master's next sample edge.
- **`rx_valid` timing:** rises SYNC_STAGES+2 cycles after the last sample edge on the pin, high for exactly 1 cycle.
- **Minimum setup, CPHA=0:** `ss_n` fall to first `sclk` edge ≥ SYNC_STAGES+3 `clk` cycles, so the first bit is on `miso` in time.
- **Simultaneous synced events in one cycle:** `ss_n` rise wins over an `sclk` edge, and that edge is dropped.

## Test plan
- **Mode 0, one byte:** preload `tx_data`=0xA5; master sends 0x3C. Expect `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C with one `rx_valid` pulse; `tx_ready` high after frame start; no error pulses.
- **Mode 3, two back-to-back words:** preload 0x81, offer 0x7E when `tx_ready` rises; master sends 0x12,0x34 under one `ss_n`. Expect the master receives 0x81,0x7E; two `rx_valid` pulses with 0x12 then 0x34.
- **Underrun, modes 1 and 2:** no `tx_data` preloaded; master sends 0xFF. Expect `tx_underrun` pulse at frame start; `miso` all 0; `rx_data`=0xFF.
- **Abort:** mode 0; raise `ss_n` after 5 bits of 0xC3. Expect `frame_err` pulse; `rx_data` keeps its prior value; no `rx_valid`; `busy` drops; next full frame of 0x55 received correctly.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle after 3 bits. Expect all outputs at reset values; remaining edges ignored; a new frame after an `ss_n` toggle works.
- **Simultaneous load and `tx_valid`:** empty buffer, `tx_valid` in the load cycle. Expect a `tx_underrun` pulse for word 1 and the offered data sent as word 2.

Source files
------------

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi into clk, deserializes mosi into rx_data
// and shifts a one-word-buffered tx_data out on miso. All four SPI modes supported.
module spi_slave #(
   parameter int SPI_MODE    = 0,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  frame_err
);

   localparam logic CPOL = 1'((SPI_MODE / 2) % 2);
   localparam logic CPHA = 1'(SPI_MODE % 2);
   localparam int   CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
   logic                    sclk_prev_q, sclk_prev_d;
   logic                    ss_prev_q, ss_prev_d;
   logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0]   buf_q, buf_d;
   logic                    buf_full_q, buf_full_d;
   logic                    first_word_q, first_word_d;
   logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    tx_underrun_q, tx_underrun_d;
   logic                    frame_err_q, frame_err_d;
   logic                    miso_q, miso_d;
   logic                    miso_oe_q, miso_oe_d;
   logic                    busy_q, busy_d;

   logic                    sclk_s, ss_s, mosi_s;
   logic                    sclk_edge, leading_edge, trailing_edge;
   logic                    sample_edge, shift_edge, ss_fall, load;
   logic [DATA_WIDTH-1:0]   rx_next;

   assign sclk_s        = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s          = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s        = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_edge     = (sclk_s != sclk_prev_q);
   assign leading_edge  = sclk_edge && (sclk_s != CPOL);
   assign trailing_edge = sclk_edge && (sclk_s == CPOL);
   assign sample_edge   = CPHA ? trailing_edge : leading_edge;
   assign shift_edge    = CPHA ? leading_edge : trailing_edge;
   assign ss_fall       = ss_prev_q && !ss_s;
   assign rx_next       = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

   always_comb begin
      state_d       = state_q;
      sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_d   = sclk_s;
      ss_prev_d     = ss_s;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      buf_d         = buf_q;
      buf_full_d    = buf_full_q;
      first_word_d  = first_word_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_underrun_d = 1'b0;
      frame_err_d   = 1'b0;
      load          = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d      = ACTIVE;
               bit_cnt_d    = '0;
               first_word_d = 1'b1;
               load         = 1'b1;
            end
         end
         ACTIVE: begin
            // Deselect takes priority; any sclk edge seen in the same cycle is dropped.
            if (ss_s) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               rx_shift_d  = '0;
            end else if (sample_edge) begin
               rx_shift_d = rx_next;
               if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (shift_edge) begin
               // A shift edge seen with the counter at 0 marks a word boundary.
               if (bit_cnt_q == '0) begin
                  if (CPHA && first_word_q) begin
                     first_word_d = 1'b0;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
         end else begin
            tx_shift_d    = '0;
            tx_underrun_d = 1'b1;
         end
      end
      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end

      busy_d    = (state_d == ACTIVE);
      miso_oe_d = (state_d == ACTIVE);
      miso_d    = (state_d == ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sclk_sync_q   <= {SYNC_STAGES{CPOL}};
         // ss_n resets as already low so a frame in progress at reset is not re-entered.
         ss_sync_q     <= '0;
         ss_prev_q     <= 1'b0;
         mosi_sync_q   <= '0;
         sclk_prev_q   <= CPOL;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         buf_q         <= '0;
         buf_full_q    <= 1'b0;
         first_word_q  <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_err_q   <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         ss_sync_q     <= ss_sync_d;
         ss_prev_q     <= ss_prev_d;
         mosi_sync_q   <= mosi_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         buf_q         <= buf_d;
         buf_full_q    <= buf_full_d;
         first_word_q  <= first_word_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_underrun_q <= tx_underrun_d;
         frame_err_q   <= frame_err_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         busy_q        <= busy_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = !buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;
   assign tx_underrun = tx_underrun_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a bit-level master model,
// with a word-level TX-buffer/RX model predicting miso words, rx words and pulse counts.
module tb_spi_slave;

   localparam int DW   = 8;
   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sclk_p [4];
   logic          ss_n_p [4];
   logic          mosi_p [4];
   logic          tx_valid_p [4];
   logic [DW-1:0] tx_data_p [4];
   logic          miso_o [4];
   logic          miso_oe_o [4];
   logic          tx_ready_o [4];
   logic [DW-1:0] rx_data_o [4];
   logic          rx_valid_o [4];
   logic          busy_o [4];
   logic          und_o [4];
   logic          ferr_o [4];

   int            checks = 0;
   int            passed = 0;
   int            rxv_cnt [4];
   int            und_cnt [4];
   int            ferr_cnt [4];
   logic [DW-1:0] rx_log [4][16];

   // Word-level model: one-entry TX buffer and last received word per instance.
   logic          mdl_full [4];
   logic [DW-1:0] mdl_buf [4];
   logic [DW-1:0] mdl_rx [4];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         spi_slave #(
            .SPI_MODE   (gi),
            .DATA_WIDTH (DW),
            .SYNC_STAGES(SYNC)
         ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .sclk       (sclk_p[gi]),
            .ss_n       (ss_n_p[gi]),
            .mosi       (mosi_p[gi]),
            .miso       (miso_o[gi]),
            .miso_oe    (miso_oe_o[gi]),
            .tx_data    (tx_data_p[gi]),
            .tx_valid   (tx_valid_p[gi]),
            .tx_ready   (tx_ready_o[gi]),
            .rx_data    (rx_data_o[gi]),
            .rx_valid   (rx_valid_o[gi]),
            .busy       (busy_o[gi]),
            .tx_underrun(und_o[gi]),
            .frame_err  (ferr_o[gi])
         );
      end
   endgenerate

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rx_valid_o[k] === 1'b1) begin
            rx_log[k][rxv_cnt[k] % 16] <= rx_data_o[k];
            rxv_cnt[k] <= rxv_cnt[k] + 1;
         end
         if (und_o[k] === 1'b1) und_cnt[k] <= und_cnt[k] + 1;
         if (ferr_o[k] === 1'b1) ferr_cnt[k] <= ferr_cnt[k] + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [6:0] status(input int m);
      return {miso_o[m], miso_oe_o[m], rx_valid_o[m], tx_ready_o[m], busy_o[m], und_o[m], ferr_o[m]};
   endfunction

   task automatic mdl_load(input int m, output logic [DW-1:0] w, inout int und);
      if (mdl_full[m]) begin
         w          = mdl_buf[m];
         mdl_full[m] = 1'b0;
      end else begin
         w = '0;
         und++;
      end
   endtask

   task automatic send_bit(input int m, input logic b, output logic mb);
      logic cpol;
      logic cpha;
      cpol = ((m / 2) % 2) == 1;
      cpha = (m % 2) == 1;
      if (!cpha) begin
         mosi_p[m] = b;
         wait_n(HALF);
         sclk_p[m] = ~cpol;
         mb = miso_o[m];
         wait_n(HALF);
         sclk_p[m] = cpol;
      end else begin
         wait_n(HALF);
         sclk_p[m] = ~cpol;
         mosi_p[m] = b;
         wait_n(HALF);
         sclk_p[m] = cpol;
         mb = miso_o[m];
      end
   endtask

   task automatic preload(input int m, input logic [DW-1:0] d);
      check("tx_ready_pre", 32'(tx_ready_o[m]), 32'(!mdl_full[m]));
      if (!mdl_full[m]) begin
         tx_data_p[m]  = d;
         tx_valid_p[m] = 1'b1;
         wait_n(1);
         tx_valid_p[m] = 1'b0;
         mdl_full[m]   = 1'b1;
         mdl_buf[m]    = d;
      end
   endtask

   // fmode: 0 no offer, 1 offer fdata once the frame has started, 2 offer in the entry-load cycle.
   task automatic run_frame(input int m, input int nw, input logic [31:0] mo, input int fmode,
                            input logic [DW-1:0] fdata, input int abort_bits);
      int            base_rx, base_und, base_fe, exp_und, nbits;
      logic [31:0]   exp_mi, mi;
      logic [DW-1:0] w, w0;
      logic          mb;
      base_rx  = rxv_cnt[m];
      base_und = und_cnt[m];
      base_fe  = ferr_cnt[m];
      exp_und  = 0;
      mi       = '0;
      nbits    = (abort_bits > 0) ? abort_bits : nw * DW;

      if (fmode == 2 && !mdl_full[m]) begin
         w0 = '0;
         exp_und++;
         mdl_full[m] = 1'b1;
         mdl_buf[m]  = fdata;
      end else begin
         mdl_load(m, w0, exp_und);
      end
      if (fmode == 1) begin
         mdl_full[m] = 1'b1;
         mdl_buf[m]  = fdata;
      end
      exp_mi = 32'(w0);
      for (int k = 1; k < nw; k++) begin
         mdl_load(m, w, exp_und);
         exp_mi = (exp_mi << DW) | 32'(w);
      end
      if ((m % 2) == 0 && abort_bits == 0) mdl_load(m, w, exp_und);
      if (abort_bits > 0) exp_mi = 32'(w0) >> (DW - abort_bits);

      ss_n_p[m] = 1'b0;
      if (fmode == 2) begin
         wait_n(SYNC);
         tx_data_p[m]  = fdata;
         tx_valid_p[m] = 1'b1;
         wait_n(1);
         tx_valid_p[m] = 1'b0;
         wait_n(6);
      end else begin
         wait_n(8);
      end
      check("busy_oe_active", 32'({busy_o[m], miso_oe_o[m]}), 32'd3);
      if (fmode == 1) begin
         check("tx_ready_after_start", 32'(tx_ready_o[m]), 32'd1);
         tx_data_p[m]  = fdata;
         tx_valid_p[m] = 1'b1;
         wait_n(1);
         tx_valid_p[m] = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         send_bit(m, mo[nw * DW - 1 - i], mb);
         mi = {mi[30:0], mb};
      end
      wait_n(HALF);
      ss_n_p[m] = 1'b1;
      wait_n(10);

      if (abort_bits == 0) mdl_rx[m] = mo[DW-1:0];
      check("miso_bits", mi, exp_mi);
      check("rx_valid_count", 32'(rxv_cnt[m] - base_rx), (abort_bits > 0) ? 32'd0 : 32'(nw));
      if (abort_bits == 0) begin
         for (int k = 0; k < nw; k++)
            check("rx_word", 32'(rx_log[m][(base_rx + k) % 16]), 32'(mo[(nw - 1 - k) * DW +: DW]));
      end
      check("rx_data_held", 32'(rx_data_o[m]), 32'(mdl_rx[m]));
      check("underrun_count", 32'(und_cnt[m] - base_und), 32'(exp_und));
      check("frame_err_count", 32'(ferr_cnt[m] - base_fe), (abort_bits > 0) ? 32'd1 : 32'd0);
      check("idle_status", 32'({miso_o[m], miso_oe_o[m], busy_o[m], tx_ready_o[m]}),
            32'({3'b000, !mdl_full[m]}));
   endtask

   initial begin
      logic mb;
      int   m, nw, fm;
      for (int k = 0; k < 4; k++) begin
         sclk_p[k]     = ((k / 2) % 2) == 1;
         ss_n_p[k]     = 1'b1;
         mosi_p[k]     = 1'b0;
         tx_valid_p[k] = 1'b0;
         tx_data_p[k]  = '0;
         mdl_full[k]   = 1'b0;
         mdl_buf[k]    = '0;
         mdl_rx[k]     = '0;
      end
      rst_n = 1'b0;
      wait_n(3);
      for (int k = 0; k < 4; k++) begin
         check("reset_status", 32'(status(k)), 32'h08);
         check("reset_rx_data", 32'(rx_data_o[k]), 32'd0);
      end
      rst_n = 1'b1;
      wait_n(4);

      preload(0, 8'hA5);
      run_frame(0, 1, 32'h3C, 0, 8'h00, 0);

      preload(3, 8'h81);
      run_frame(3, 2, 32'h1234, 1, 8'h7E, 0);

      run_frame(1, 1, 32'hFF, 0, 8'h00, 0);
      run_frame(2, 1, 32'hFF, 0, 8'h00, 0);

      run_frame(0, 1, 32'hC3, 0, 8'h00, 5);
      run_frame(0, 1, 32'h55, 0, 8'h00, 0);

      run_frame(0, 2, $urandom, 2, 8'($urandom), 0);
      run_frame(1, 2, $urandom, 2, 8'($urandom), 0);

      for (int it = 0; it < 12; it++) begin
         m  = int'($urandom_range(3, 0));
         nw = int'($urandom_range(2, 1));
         fm = int'($urandom_range(1, 0));
         if ($urandom_range(1, 0) == 1) preload(m, 8'($urandom));
         run_frame(m, nw, $urandom, fm, 8'($urandom), 0);
      end

      // Reset in the middle of a mode-0 frame after three bits.
      ss_n_p[0] = 1'b0;
      wait_n(8);
      for (int i = 0; i < 3; i++) send_bit(0, 1'b1, mb);
      rst_n = 1'b0;
      wait_n(1);
      for (int k = 0; k < 4; k++) begin
         check("midreset_status", 32'(status(k)), 32'h08);
         check("midreset_rx_data", 32'(rx_data_o[k]), 32'd0);
         mdl_full[k] = 1'b0;
         mdl_rx[k]   = '0;
      end
      rst_n = 1'b1;
      begin
         int base_rx;
         base_rx = rxv_cnt[0];
         for (int i = 0; i < 5; i++) send_bit(0, 1'b1, mb);
         wait_n(6);
         check("midreset_ignored_rx", 32'(rxv_cnt[0] - base_rx), 32'd0);
         check("midreset_not_busy", 32'({busy_o[0], miso_oe_o[0]}), 32'd0);
      end
      ss_n_p[0] = 1'b1;
      wait_n(10);
      preload(0, 8'($urandom));
      run_frame(0, 1, $urandom, 0, 8'h00, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
